ram_burst_port: RTL and testbench

- Parametrised successor to the CPU's stub RAM read/write blocks.
- One unit holds the memory array and serves both read and write bursts.
- Uses a level start/done handshake; each burst moves a variable number of words between a single-port synchronous RAM and a wide packed buffer.
- Serves instruction fetch, stack load/store and register-file spill/fill (SUPERMANDIVE/GETUP).

---
 rtl/ram_burst_port.sv | 174 +++++++++++++++++
 tb/tb_ram_burst_port.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ram_burst_port.sv
// Burst port onto a single-port synchronous RAM: moves 1..MAX_WORDS words between
// the memory and a packed buffer (word 0 in the MSBs) under a level start/done handshake.
//
//   state     | meaning
//   IDLE      | waiting for start, latches burst parameters
//   RUN       | one RAM access per edge (write, or read address issue)
//   READ_TAIL | captures the last read word (1-cycle RAM latency)
//   DONE      | done held until start drops
module ram_burst_port #(
    parameter  int DATA_W    = 16,
    parameter  int MAX_WORDS = 16,
    parameter  int DEPTH     = 1024,
    localparam int BUF_W     = DATA_W * MAX_WORDS,
    localparam int AW        = $clog2(DEPTH),
    localparam int IW        = $clog2(MAX_WORDS) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             write,
    input  logic [15:0]      address,
    input  logic [15:0]      words,
    input  logic [BUF_W-1:0] wdata,
    output logic [BUF_W-1:0] rdata,
    output logic             done,
    output logic             busy,
    output logic             error
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RUN       = 2'd1;
    localparam logic [1:0] S_READ_TAIL = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    cap_idx_q, cap_idx_d;
    logic             write_q, write_d;
    logic             rd_vld_q, rd_vld_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [BUF_W-1:0] wbuf_q, wbuf_d;
    logic [BUF_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] wword;
    logic [AW-1:0]     ram_addr;
    logic              mem_we;
    logic              unused_addr;

    assign unused_addr = ^address[15:AW];

    // Address arithmetic is AW bits wide, so bursts wrap at the top of memory.
    assign ram_addr = addr_q + AW'(idx_q);

    always_comb begin
        wword = '0;
        for (int k = 0; k < MAX_WORDS; k++) begin
            if (idx_q == IW'(k)) wword = wbuf_q[BUF_W-1-k*DATA_W -: DATA_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        last_d    = last_q;
        idx_d     = idx_q;
        cap_idx_d = cap_idx_q;
        write_d   = write_q;
        rd_vld_d  = 1'b0;
        done_d    = done_q;
        error_d   = error_q;
        wbuf_d    = wbuf_q;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;

        if (rd_vld_q) begin
            for (int k = 0; k < MAX_WORDS; k++) begin
                if (cap_idx_q == IW'(k)) rdata_d[BUF_W-1-k*DATA_W -: DATA_W] = ram_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    addr_d  = address[AW-1:0];
                    write_d = write;
                    wbuf_d  = wdata;
                    idx_d   = '0;
                    error_d = 1'b0;
                    if (words == 16'd0 || words > 16'(MAX_WORDS)) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        last_d  = IW'(words - 16'd1);
                        state_d = S_RUN;
                        if (!write) rdata_d = '0;
                    end
                end
            end
            S_RUN: begin
                mem_we    = write_q;
                rd_vld_d  = !write_q;
                cap_idx_d = idx_q;
                idx_d     = idx_q + IW'(1);
                if (idx_q == last_q) begin
                    if (write_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ_TAIL;
                    end
                end
            end
            S_READ_TAIL: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                // done always shows for at least one cycle, even if start already fell.
                if (done_q && !start) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            last_q    <= '0;
            idx_q     <= '0;
            cap_idx_q <= '0;
            write_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            wbuf_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            cap_idx_q <= cap_idx_d;
            write_q   <= write_d;
            rd_vld_q  <= rd_vld_d;
            done_q    <= done_d;
            error_q   <= error_d;
            wbuf_q    <= wbuf_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[ram_addr] <= wword;
        else        ram_q         <= mem[ram_addr];
    end

    assign rdata = rdata_q;
    assign done  = done_q;
    assign busy  = (state_q != S_IDLE);
    assign error = error_q;

endmodule

// File: tb/tb_ram_burst_port.sv
// Scoreboard bench for ram_burst_port: expected latency/error/rdata pushed when a
// burst is driven, popped and compared when done is observed.
module tb_ram_burst_port;

    localparam int DATA_W    = 16;
    localparam int MAX_WORDS = 16;
    localparam int DEPTH     = 1024;
    localparam int BUF_W     = DATA_W * MAX_WORDS;

    typedef struct {
        int               lat;
        logic             err;
        logic [BUF_W-1:0] rd;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             write = 1'b0;
    logic [15:0]      address = '0;
    logic [15:0]      words = '0;
    logic [BUF_W-1:0] wdata = '0;
    logic [BUF_W-1:0] rdata;
    logic             done;
    logic             busy;
    logic             error;

    logic [DATA_W-1:0] mdl [DEPTH];
    logic [BUF_W-1:0]  last_rd = '0;
    exp_t              sb[$];
    int                n_chk = 0;
    int                n_err = 0;

    always #5 clock = ~clock;

    ram_burst_port #(.DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .write(write),
        .address(address), .words(words), .wdata(wdata),
        .rdata(rdata), .done(done), .busy(busy), .error(error)
    );

    task automatic chk(input string tag, input logic [BUF_W-1:0] obs, input logic [BUF_W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BUF_W-1:0] pack_word(input int k, input logic [DATA_W-1:0] v);
        logic [BUF_W-1:0] r;
        r = '0;
        r[BUF_W-1-k*DATA_W -: DATA_W] = v;
        return r;
    endfunction

    task automatic run_burst(input string tag, input logic wr, input logic [15:0] a,
                             input logic [15:0] n, input logic [BUF_W-1:0] wd, input int hold);
        exp_t e;
        int   cyc;
        e.err = (n == 16'd0) || (n > 16'(MAX_WORDS));
        e.lat = e.err ? 1 : (wr ? int'(n) : int'(n) + 1);
        if (!e.err) begin
            if (wr) begin
                for (int k = 0; k < int'(n); k++)
                    mdl[(int'(a) + k) % DEPTH] = wd[BUF_W-1-k*DATA_W -: DATA_W];
            end else begin
                last_rd = '0;
                for (int k = 0; k < int'(n); k++)
                    last_rd |= pack_word(k, mdl[(int'(a) + k) % DEPTH]);
            end
        end
        e.rd = last_rd;
        sb.push_back(e);

        @(negedge clock);
        start = 1'b1; write = wr; address = a; words = n; wdata = wd;
        @(posedge clock);
        #1;
        address = ~a; words = 16'd5; wdata = ~wd; write = ~wr;
        cyc = 0;
        while (cyc <= 40) begin
            @(posedge clock);
            cyc++;
            #1;
            if (done) break;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, BUF_W'(cyc), BUF_W'(e.lat));
        chk({tag, "_err"}, BUF_W'(error), BUF_W'(e.err));
        chk({tag, "_rdata"}, rdata, e.rd);
        chk({tag, "_busy"}, BUF_W'(busy), BUF_W'(1));
        if (hold > 0) begin
            repeat (hold) @(posedge clock);
            #1;
            chk({tag, "_hold_done"}, BUF_W'(done), BUF_W'(1));
        end
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #1;
        chk({tag, "_drop_done"}, BUF_W'(done), BUF_W'(0));
        chk({tag, "_drop_busy"}, BUF_W'(busy), BUF_W'(0));
    endtask

    initial begin
        logic [BUF_W-1:0] wd;

        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_done", BUF_W'(done), BUF_W'(0));
        chk("rst_busy", BUF_W'(busy), BUF_W'(0));
        chk("rst_error", BUF_W'(error), BUF_W'(0));
        chk("rst_rdata", rdata, '0);
        @(negedge clock);
        reset_n = 1'b1;

        wd = {48'hAAAA_5555_1234, 208'h0};
        run_burst("wr3", 1'b1, 16'h0010, 16'd3, wd, 0);
        run_burst("rd3", 1'b0, 16'h0010, 16'd3, '0, 0);
        chk("rd3_const", rdata, {48'hAAAA_5555_1234, 208'h0});

        wd = '0;
        for (int k = 0; k < MAX_WORDS; k++) wd |= pack_word(k, DATA_W'(k));
        run_burst("wr16", 1'b1, 16'h0100, 16'd16, wd, 0);
        run_burst("rd16", 1'b0, 16'h0100, 16'd16, '0, 0);
        chk("rd16_exact", rdata, wd);

        wd = {64'h1111_2222_3333_4444, 192'h0};
        run_burst("wr_wrap", 1'b1, 16'h03FE, 16'd4, wd, 0);
        run_burst("rd_wrap", 1'b0, 16'h0000, 16'd2, '0, 0);
        chk("rd_wrap_const", rdata, {32'h3333_4444, 224'h0});
        run_burst("rd_top", 1'b0, 16'h03FE, 16'd2, '0, 0);
        chk("rd_top_const", rdata, {32'h1111_2222, 224'h0});

        run_burst("len0", 1'b1, 16'h0010, 16'd0, {BUF_W{1'b1}}, 0);
        run_burst("len17", 1'b1, 16'h0010, 16'd17, {BUF_W{1'b1}}, 0);
        run_burst("rd_after_ill", 1'b0, 16'h0010, 16'd3, '0, 0);
        chk("rd_after_ill_const", rdata, {48'hAAAA_5555_1234, 208'h0});

        wd = {32'hBEEF_F00D, 224'h0};
        run_burst("hs_wr", 1'b1, 16'h0020, 16'd2, wd, 10);
        run_burst("hs_rd", 1'b0, 16'h0020, 16'd2, '0, 0);
        chk("hs_rd_const", rdata, {32'hBEEF_F00D, 224'h0});

        wd = '0;
        for (int k = 0; k < 8; k++) wd |= pack_word(k, 16'hB000 + 16'(k));
        run_burst("pre_old", 1'b1, 16'h0200, 16'd8, wd, 0);
        wd = '0;
        for (int k = 0; k < 8; k++) wd |= pack_word(k, 16'hC000 + 16'(k));
        @(negedge clock);
        start = 1'b1; write = 1'b1; address = 16'h0200; words = 16'd8; wdata = wd;
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_done", BUF_W'(done), BUF_W'(0));
        chk("mid_rst_busy", BUF_W'(busy), BUF_W'(0));
        chk("mid_rst_rdata", rdata, '0);
        for (int k = 0; k < 3; k++) mdl[16'h0200 + k] = 16'hC000 + 16'(k);
        last_rd = '0;
        @(negedge clock);
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        run_burst("rd_after_rst", 1'b0, 16'h0200, 16'd8, '0, 0);
        chk("rd_after_rst_const", rdata,
            {64'hC000_C001_C002_B003, 64'hB004_B005_B006_B007, 128'h0});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
